// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared fetch-stage defaults: bus widths, NOP encoding and
//               fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_DEF_ADDRESS_WIDTH = 32;
    localparam int c_DEF_INSTR_WIDTH   = 32;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction-memory read channel between fetch unit (master)
//               and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
);
    logic                     o_IMemReq;
    logic [ADDRESS_WIDTH-1:0] o_IMemAddr;
    logic                     i_IMemValid;
    logic [INSTR_WIDTH-1:0]   i_IMemRdata;

    modport master (
        output o_IMemReq,
        output o_IMemAddr,
        input  i_IMemValid,
        input  i_IMemRdata
    );

    modport slave (
        input  o_IMemReq,
        input  o_IMemAddr,
        output i_IMemValid,
        output i_IMemRdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter with sequential increment and word-aligned
//               redirect; redirect has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_inc_en,
    input  logic                     i_redirect_en,
    input  logic [ADDRESS_WIDTH-1:0] i_target,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic [ADDRESS_WIDTH-1:0] o_pc_plus4
);
    localparam logic [ADDRESS_WIDTH-1:0] c_ALIGN_MASK = ~ADDRESS_WIDTH'(3);
    localparam logic [ADDRESS_WIDTH-1:0] c_FOUR       = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] r_pc;

    // Low two bits are forced to zero so fetch addresses are always word aligned.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_pc <= RESET_PC & c_ALIGN_MASK;
        end else if (i_redirect_en) begin
            r_pc <= i_target & c_ALIGN_MASK;
        end else if (i_inc_en) begin
            r_pc <= r_pc + c_FOUR;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + c_FOUR;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Single-outstanding instruction fetch stage with IDLE/REQ/HOLD
//               FSM, hold register and redirect/kill handling.
//               Optional: FETCH_STALL_CNT_EN adds o_FetchStallCnt.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = c_DEF_ADDRESS_WIDTH,
    parameter int                       INSTR_WIDTH   = c_DEF_INSTR_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_n_EN,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCBranchD,
    instr_fetch_unit_if.master       imem,
    output logic [INSTR_WIDTH-1:0]   o_InstrF,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4F,
    output logic                     o_ValidF,
    output logic                     o_StallReqF
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]              o_FetchStallCnt
`endif
);
    localparam logic [INSTR_WIDTH-1:0] c_NOP = INSTR_WIDTH'(c_NOP_INSTR);

    fetch_state_t             r_state;
    fetch_state_t             w_state_nxt;
    logic                     r_kill;
    logic                     w_kill_nxt;
    logic                     r_valid;
    logic                     w_valid_nxt;
    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [INSTR_WIDTH-1:0]   w_instr_nxt;
    logic                     w_pc_inc;
    logic                     w_pc_redirect;
    logic                     w_imem_req;
    logic [ADDRESS_WIDTH-1:0] w_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;

    fetch_pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pc_reg (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_inc_en      (w_pc_inc),
        .i_redirect_en (w_pc_redirect),
        .i_target      (i_PCBranchD),
        .o_pc          (w_pc),
        .o_pc_plus4    (w_pc_plus4)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= c_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_kill_nxt    = r_kill;
        w_valid_nxt   = r_valid;
        w_instr_nxt   = r_instr;
        w_pc_inc      = 1'b0;
        w_pc_redirect = 1'b0;
        w_imem_req    = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end
            REQ: begin
                w_imem_req = 1'b1;
                // Any response ends the outstanding request; a killed one is dropped
                // and the request is reissued at the (already redirected) PC.
                if (imem.i_IMemValid) begin
                    w_kill_nxt = 1'b0;
                    if (!r_kill && !i_PCSrcD) begin
                        w_instr_nxt = imem.i_IMemRdata;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (i_PCSrcD) begin
                    w_kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (!i_n_EN && !i_PCSrcD) begin
                    w_pc_inc    = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (i_PCSrcD) begin
            w_pc_redirect = 1'b1;
            w_pc_inc      = 1'b0;
            w_valid_nxt   = 1'b0;
            w_state_nxt   = REQ;
        end
    end

    assign imem.o_IMemReq  = w_imem_req;
    assign imem.o_IMemAddr = w_pc;

    assign o_InstrF    = r_valid ? r_instr : c_NOP;
    assign o_PCPlus4F  = w_pc_plus4;
    assign o_ValidF    = r_valid;
    assign o_StallReqF = ~r_valid;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_stall_cnt <= '0;
        end else if (o_StallReqF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_FetchStallCnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
